adc_chan_sequencer: RTL and testbench

//  N-channel successor of the two-channel ADC switch: scans 1..NUM_CHAN bolometer ADC channels in order,

---
 rtl/adc_chan_sequencer_pkg.sv | 12 +
 rtl/adc_chan_sequencer_mux.sv | 16 +
 rtl/adc_chan_sequencer.sv | 114 +++++++++++
 tb/tb_adc_chan_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_chan_sequencer_pkg.sv
// adc_chan_sequencer_pkg: shared state encoding and width helpers for the channel sequencer
package adc_chan_sequencer_pkg;
  localparam int ADC_WIDTH_DEF = 14;
  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_SAMPLE = 2'd1,
    SEQ_DONE   = 2'd2
  } seq_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/adc_chan_sequencer_mux.sv
// adc_chan_mux: combinational select of one channel's sample and strobe
module adc_chan_mux
  import adc_chan_sequencer_pkg::*;
#(
  parameter int ADC_WIDTH = ADC_WIDTH_DEF,
  parameter int NUM_CHAN  = 4
) (
  input  logic [NUM_CHAN*ADC_WIDTH-1:0] can_in,
  input  logic [NUM_CHAN-1:0]           can_valid,
  input  logic [idx_w(NUM_CHAN)-1:0]    sel,
  output logic [ADC_WIDTH-1:0]          sel_data,
  output logic                          sel_valid
);
  assign sel_data  = can_in[int'(sel)*ADC_WIDTH +: ADC_WIDTH];
  assign sel_valid = can_valid[sel];
endmodule

// File: rtl/adc_chan_sequencer.sv
// adc_chan_sequencer: scans active ADC channels in order, capturing a fixed sample count from each
module adc_chan_sequencer
  import adc_chan_sequencer_pkg::*;
#(
  parameter int ADC_WIDTH        = ADC_WIDTH_DEF,
  parameter int NUM_CHAN         = 4,
  parameter int SAMPLES_PER_CHAN = 80
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            START,
  input  logic                            ABORT,
  input  logic                            CONT_MODE,
  input  logic [$clog2(NUM_CHAN+1)-1:0]   ACTIVE_CHAN,
  input  logic                            IN_BUF_EN,
  input  logic [NUM_CHAN*ADC_WIDTH-1:0]   CAN_IN,
  input  logic [NUM_CHAN-1:0]             CAN_VALID,
  output logic [NUM_CHAN-1:0]             IN_BUF_EN_CAN,
  output logic [ADC_WIDTH-1:0]            DATA_OUT,
  output logic                            DATA_VALID,
  output logic [idx_w(NUM_CHAN)-1:0]      CHAN_ID,
  output logic                            LINE_DONE,
  output logic                            BUSY,
  output logic                            ERR_CFG
);
  localparam int AW = $clog2(NUM_CHAN+1);
  localparam int CW = idx_w(NUM_CHAN);
  localparam int SW = idx_w(SAMPLES_PER_CHAN);
  seq_state_e state_q, state_d;
  logic [CW-1:0] cur_q, cur_d, chan_q, chan_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] act_q, act_d;
  logic [ADC_WIDTH-1:0] data_q, data_d, sel_data;
  logic valid_q, valid_d, err_q, err_d, sel_valid, accept, cfg_ok;
  adc_chan_mux #(.ADC_WIDTH(ADC_WIDTH), .NUM_CHAN(NUM_CHAN)) u_mux (
    .can_in   (CAN_IN),
    .can_valid(CAN_VALID),
    .sel      (cur_q),
    .sel_data (sel_data),
    .sel_valid(sel_valid)
  );
  assign accept        = (state_q == SEQ_SAMPLE) && IN_BUF_EN && sel_valid;
  assign cfg_ok        = (ACTIVE_CHAN != '0) && (ACTIVE_CHAN <= AW'(NUM_CHAN));
  assign IN_BUF_EN_CAN = ((state_q == SEQ_SAMPLE) && IN_BUF_EN) ? NUM_CHAN'(1) << cur_q : '0;
  assign LINE_DONE     = state_q == SEQ_DONE;
  assign BUSY          = state_q != SEQ_IDLE;
  assign DATA_OUT      = data_q;
  assign DATA_VALID    = valid_q;
  assign CHAN_ID       = chan_q;
  assign ERR_CFG       = err_q;
  // next-state: abort wins, then per-state scan/start handling; pulses default low
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (ABORT) begin
      state_d = SEQ_IDLE;
      cur_d   = '0;
      cnt_d   = '0;
    end else if (state_q == SEQ_IDLE) begin
      if (START && cfg_ok) begin
        state_d = SEQ_SAMPLE;
        act_d   = ACTIVE_CHAN;
        cur_d   = '0;
        cnt_d   = '0;
      end
      err_d = START && !cfg_ok;
    end else if (state_q == SEQ_SAMPLE) begin
      if (accept) begin
        data_d  = sel_data;
        chan_d  = cur_q;
        valid_d = 1'b1;
        if (int'(cnt_q) == SAMPLES_PER_CHAN - 1) begin
          cnt_d = '0;
          if (int'(cur_q) == int'(act_q) - 1) state_d = SEQ_DONE;
          else cur_d = cur_q + CW'(1);
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
    end else begin
      state_d = CONT_MODE ? SEQ_SAMPLE : SEQ_IDLE;
      cur_d   = '0;
      cnt_d   = '0;
    end
  end
  // state, counters and registered output stream
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= SEQ_IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      act_q   <= '0;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_adc_chan_sequencer.sv
// tb_adc_chan_sequencer: line-position reference model plus directed scans of the sequencer
module tb_adc_chan_sequencer;
  localparam int W = 14, N = 4, S = 3, AW = 3, CW = 2;
  logic CLK = 0, RST_N = 0, START = 0, ABORT = 0, CONT_MODE = 0, IN_BUF_EN = 0;
  logic [AW-1:0] ACTIVE_CHAN = '0;
  logic [N*W-1:0] CAN_IN = '0;
  logic [N-1:0] CAN_VALID = '0;
  logic [N-1:0] IN_BUF_EN_CAN;
  logic [W-1:0] DATA_OUT;
  logic DATA_VALID, LINE_DONE, BUSY, ERR_CFG;
  logic [CW-1:0] CHAN_ID;
  adc_chan_sequencer #(.ADC_WIDTH(W), .NUM_CHAN(N), .SAMPLES_PER_CHAN(S)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT), .CONT_MODE(CONT_MODE),
    .ACTIVE_CHAN(ACTIVE_CHAN), .IN_BUF_EN(IN_BUF_EN), .CAN_IN(CAN_IN), .CAN_VALID(CAN_VALID),
    .IN_BUF_EN_CAN(IN_BUF_EN_CAN), .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .CHAN_ID(CHAN_ID),
    .LINE_DONE(LINE_DONE), .BUSY(BUSY), .ERR_CFG(ERR_CFG)
  );
  always #5 CLK = ~CLK;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  // model: a scan is a linear walk over positions 0..act*S-1; channel = position / S
  bit m_busy = 0, m_done = 0, m_valid = 0, m_err = 0;
  int m_pos = 0, m_act = 0, m_chan = 0;
  logic [W-1:0] m_data = '0;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_busy = 0; m_done = 0; m_valid = 0; m_err = 0; m_pos = 0; m_act = 0; m_chan = 0; m_data = '0;
    end else begin
      m_valid = 0;
      m_err = 0;
      if (ABORT) begin
        m_busy = 0; m_done = 0; m_pos = 0;
      end else if (m_done) begin
        m_done = 0; m_pos = 0; m_busy = CONT_MODE;
      end else if (m_busy) begin
        if (IN_BUF_EN && CAN_VALID[m_pos / S]) begin
          m_chan = m_pos / S;
          m_data = CAN_IN[m_chan*W +: W];
          m_valid = 1;
          m_pos++;
          if (m_pos == m_act * S) begin
            m_busy = 0; m_done = 1;
          end
        end
      end else if (START) begin
        if (ACTIVE_CHAN >= 1 && ACTIVE_CHAN <= N) begin
          m_busy = 1; m_act = ACTIVE_CHAN; m_pos = 0;
        end else m_err = 1;
      end
    end
  end
  int qch[$], qd[$];
  int lines = 0, errs = 0;
  // compare every cycle, after both DUT and model have settled
  always @(posedge CLK) begin
    #2;
    chk("busy", BUSY, m_busy || m_done);
    chk("line_done", LINE_DONE, m_done);
    chk("err_cfg", ERR_CFG, m_err);
    chk("data_valid", DATA_VALID, m_valid);
    chk("data_out", DATA_OUT, m_data);
    chk("chan_id", CHAN_ID, m_chan);
    chk("buf_en_can", IN_BUF_EN_CAN, (m_busy && IN_BUF_EN) ? (64'd1 << (m_pos / S)) : 64'd0);
    if (DATA_VALID) begin
      qch.push_back(CHAN_ID);
      qd.push_back(DATA_OUT);
    end
    if (LINE_DONE) lines++;
    if (ERR_CFG) errs++;
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic start_line(input int act);
    ACTIVE_CHAN = AW'(act);
    START = 1;
    @(negedge CLK);
    START = 0;
  endtask
  task automatic wait_q(input int n);
    int k = 0;
    while (qch.size() < n && k < 200) begin
      @(negedge CLK);
      k++;
    end
    chk("wait_samples", qch.size(), n);
  endtask
  task automatic wait_done();
    int k = 0;
    while (!LINE_DONE && k < 200) begin
      @(negedge CLK);
      k++;
    end
    chk("line_done_seen", LINE_DONE, 1);
  endtask
  task automatic check_seq(input string nm, input int e[$]);
    chk({nm, "_count"}, qch.size(), e.size());
    for (int i = 0; i < e.size() && i < qch.size(); i++) begin
      chk({nm, "_chan"}, qch[i], e[i]);
      chk({nm, "_data"}, qd[i], 'h100 + e[i]);
    end
  endtask
  initial begin
    int e0;
    for (int k = 0; k < N; k++) CAN_IN[k*W +: W] = W'('h100 + k);
    cyc(3);
    chk("rst_busy", BUSY, 0);
    chk("rst_valid", DATA_VALID, 0);
    chk("rst_en", IN_BUF_EN_CAN, 0);
    chk("rst_data", DATA_OUT, 0);
    RST_N = 1;
    IN_BUF_EN = 1;
    cyc(2);
    // full 4-channel line
    CAN_VALID = '1;
    start_line(4);
    wait_done();
    check_seq("line4", '{0,0,0,1,1,1,2,2,2,3,3,3});
    cyc(1);
    chk("line4_idle", BUSY, 0);
    chk("line4_lines", lines, 1);
    // rejected configurations
    qch.delete(); qd.delete();
    e0 = errs;
    start_line(0);
    cyc(2);
    start_line(5);
    cyc(2);
    chk("cfg_err_pulses", errs - e0, 2);
    chk("cfg_busy", BUSY, 0);
    chk("cfg_no_data", qch.size(), 0);
    // continuous mode, two lines of two channels
    lines = 0;
    CONT_MODE = 1;
    start_line(2);
    wait_done();
    cyc(1);
    wait_done();
    CONT_MODE = 0;
    cyc(2);
    chk("cont_lines", lines, 2);
    chk("cont_idle", BUSY, 0);
    check_seq("cont", '{0,0,0,1,1,1,0,0,0,1,1,1});
    // pause on IN_BUF_EN low mid channel 1
    qch.delete(); qd.delete();
    start_line(2);
    wait_q(4);
    IN_BUF_EN = 0;
    repeat (5) begin
      @(negedge CLK);
      chk("pause_en", IN_BUF_EN_CAN, 0);
      chk("pause_valid", DATA_VALID, 0);
    end
    chk("pause_count", qch.size(), 4);
    IN_BUF_EN = 1;
    wait_done();
    check_seq("pause", '{0,0,0,1,1,1});
    cyc(2);
    // foreign strobes ignored, single-channel bypass
    qch.delete(); qd.delete();
    CAN_VALID = '0;
    start_line(1);
    for (int i = 0; i < 40 && !LINE_DONE; i++) begin
      CAN_VALID = {i[0], ~i[0], 1'b0, (i % 3) == 0};
      @(negedge CLK);
    end
    chk("bypass_done", LINE_DONE, 1);
    check_seq("bypass", '{0,0,0});
    cyc(2);
    // abort during channel 2
    qch.delete(); qd.delete();
    lines = 0;
    CAN_VALID = '1;
    start_line(4);
    wait_q(7);
    ABORT = 1;
    @(negedge CLK);
    ABORT = 0;
    chk("abort_busy", BUSY, 0);
    chk("abort_done", LINE_DONE, 0);
    chk("abort_en", IN_BUF_EN_CAN, 0);
    chk("abort_valid", DATA_VALID, 0);
    cyc(3);
    chk("abort_count", qch.size(), 7);
    chk("abort_lines", lines, 0);
    // reset mid-scan
    start_line(4);
    wait_q(9);
    RST_N = 0;
    #1;
    chk("arst_busy", BUSY, 0);
    chk("arst_valid", DATA_VALID, 0);
    chk("arst_data", DATA_OUT, 0);
    chk("arst_chan", CHAN_ID, 0);
    chk("arst_en", IN_BUF_EN_CAN, 0);
    cyc(2);
    RST_N = 1;
    cyc(3);
    chk("arst_idle", BUSY, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
